// File: rtl/mp3_input_pkg.sv
// Shared register map, control bit positions and flag-field placement for
// the MP3 player button/switch input controller.
package mp3_input_pkg;

  typedef enum logic [1:0] {
    REG_STATE = 2'd0,
    REG_FLAGS = 2'd1,
    REG_MASK  = 2'd2,
    REG_CTRL  = 2'd3
  } reg_addr_e;

  localparam int CTRL_REPEAT_EN_BIT = 0;

  // Button flags occupy the low bits; switch flags follow directly above.
  localparam int FLAG_BTN_BASE = 0;

  function automatic int flag_sw_base(input int n_btn);
    return FLAG_BTN_BASE + n_btn;
  endfunction

endpackage

// File: rtl/mp3_debounce_chan.sv
// One input channel: 2-flop synchroniser, optional polarity inversion and a
// stability counter that commits a new debounced level after DEBOUNCE_CYC cycles.
module mp3_debounce_chan #(
  parameter int DEBOUNCE_CYC = 50000,
  parameter bit INVERT       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic change
);

  localparam int CW = $clog2(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync0_q, sync0_d;
  logic          sync1_q, sync1_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          settle;

  always_comb begin
    sync0_d = raw ^ INVERT;
    sync1_d = sync0_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    settle  = 1'b0;
    // Any cycle where the synchronised input agrees with the committed level
    // restarts the stability window, so glitches shorter than it never land.
    if (sync1_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync1_q;
      cnt_d   = '0;
      settle  = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync0_q <= sync0_d;
      sync1_q <= sync1_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level  = level_q;
  assign change = settle;

endmodule

// File: rtl/mp3_input_ctrl.sv
// Avalon-MM input controller: debounced buttons/switches, sticky event flags
// with write-1-to-clear, per-flag irq mask and button auto-repeat.
module mp3_input_ctrl
  import mp3_input_pkg::*;
#(
  parameter int N_BTN          = 4,
  parameter int N_SW           = 3,
  parameter int DEBOUNCE_CYC   = 50000,
  parameter int REPEAT_DELAY   = 25000000,
  parameter int REPEAT_PERIOD  = 5000000,
  parameter int BTN_ACTIVE_LOW = 1
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [N_BTN-1:0]  buttons_export,
  input  logic [N_SW-1:0]   switchs_export,
  input  logic [1:0]        address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq
);

  localparam int NF       = N_BTN + N_SW;
  localparam int SW_BASE  = flag_sw_base(N_BTN);
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW       = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HW-1:0] DELAY_LAST  = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] PERIOD_LAST = HW'(REPEAT_PERIOD - 1);

  logic [N_BTN-1:0] btn_level, btn_change;
  logic [N_SW-1:0]  sw_level, sw_change;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    mp3_debounce_chan #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .INVERT       (BTN_ACTIVE_LOW != 0)
    ) u_chan (
      .clk    (clk_clk),
      .rst_n  (reset_reset_n),
      .raw    (buttons_export[i]),
      .level  (btn_level[i]),
      .change (btn_change[i])
    );
  end

  for (genvar j = 0; j < N_SW; j++) begin : g_sw
    mp3_debounce_chan #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .INVERT       (1'b0)
    ) u_chan (
      .clk    (clk_clk),
      .rst_n  (reset_reset_n),
      .raw    (switchs_export[j]),
      .level  (sw_level[j]),
      .change (sw_change[j])
    );
  end

  // Register state
  logic [N_BTN-1:0][HW-1:0] hold_q, hold_d;
  logic [N_BTN-1:0]         rep_q, rep_d;
  logic [N_BTN-1:0]         rpt_fire;
  logic [NF-1:0]            flags_q, flags_d;
  logic [NF-1:0]            mask_q, mask_d;
  logic                     repeat_en_q, repeat_en_d;
  logic [31:0]              readdata_q, readdata_d;
  logic                     irq_q, irq_d;

  reg_addr_e     addr;
  logic          wr_flags, wr_mask, wr_ctrl;
  logic [NF-1:0] flag_set, flag_clr;
  logic [31:0]   rdata_mux;
  logic          unused_wdata;

  assign addr         = reg_addr_e'(address);
  assign unused_wdata = ^writedata;

  // rep_q marks that the first (long) delay has elapsed, so later repeats
  // use the shorter period; both clear on release or when repeat is off.
  always_comb begin
    hold_d   = hold_q;
    rep_d    = rep_q;
    rpt_fire = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (!btn_level[i] || !repeat_en_q) begin
        hold_d[i] = '0;
        rep_d[i]  = 1'b0;
      end else if (hold_q[i] == (rep_q[i] ? PERIOD_LAST : DELAY_LAST)) begin
        rpt_fire[i] = 1'b1;
        hold_d[i]   = '0;
        rep_d[i]    = 1'b1;
      end else begin
        hold_d[i] = hold_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    flag_set = '0;
    for (int i = 0; i < N_BTN; i++) begin
      // btn_level is still the old level here, so change & ~level is a press.
      flag_set[FLAG_BTN_BASE + i] = (btn_change[i] & ~btn_level[i]) | rpt_fire[i];
    end
    for (int j = 0; j < N_SW; j++) begin
      flag_set[SW_BASE + j] = sw_change[j];
    end
  end

  always_comb begin
    wr_flags    = write && (addr == REG_FLAGS);
    wr_mask     = write && (addr == REG_MASK);
    wr_ctrl     = write && (addr == REG_CTRL);
    flag_clr    = wr_flags ? writedata[NF-1:0] : '0;
    // Set is OR-ed after the clear so a coincident event is never lost.
    flags_d     = (flags_q & ~flag_clr) | flag_set;
    mask_d      = wr_mask ? writedata[NF-1:0] : mask_q;
    repeat_en_d = wr_ctrl ? writedata[CTRL_REPEAT_EN_BIT] : repeat_en_q;
    irq_d       = |(flags_q & mask_q);
  end

  always_comb begin
    rdata_mux = '0;
    case (addr)
      REG_STATE: begin
        rdata_mux[N_BTN-1:0]       = btn_level;
        rdata_mux[SW_BASE +: N_SW] = sw_level;
      end
      REG_FLAGS: rdata_mux[NF-1:0] = flags_q;
      REG_MASK:  rdata_mux[NF-1:0] = mask_q;
      REG_CTRL:  rdata_mux[CTRL_REPEAT_EN_BIT] = repeat_en_q;
      default:   rdata_mux = '0;
    endcase
    readdata_d = read ? rdata_mux : readdata_q;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      hold_q      <= '0;
      rep_q       <= '0;
      flags_q     <= '0;
      mask_q      <= '0;
      repeat_en_q <= 1'b0;
      readdata_q  <= '0;
      irq_q       <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      rep_q       <= rep_d;
      flags_q     <= flags_d;
      mask_q      <= mask_d;
      repeat_en_q <= repeat_en_d;
      readdata_q  <= readdata_d;
      irq_q       <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_mp3_input_ctrl.sv
// Directed bench for mp3_input_ctrl with short debounce/repeat parameters;
// edges are counted from the input change (E1 = first rising clock after it).
module tb_mp3_input_ctrl;

  localparam logic [1:0] A_STATE = 2'd0;
  localparam logic [1:0] A_FLAGS = 2'd1;
  localparam logic [1:0] A_MASK  = 2'd2;
  localparam logic [1:0] A_CTRL  = 2'd3;

  // Clock / reset
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  buttons_export;
  logic [2:0]  switchs_export;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  int errors = 0;
  int checks = 0;
  int nset;
  int got[8];
  logic [31:0] rv;

  initial forever #5 clk = ~clk;

  mp3_input_ctrl #(
    .N_BTN          (4),
    .N_SW           (3),
    .DEBOUNCE_CYC   (4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8),
    .BTN_ACTIVE_LOW (1)
  ) dut (
    .clk_clk        (clk),
    .reset_reset_n  (rst_n),
    .buttons_export (buttons_export),
    .switchs_export (switchs_export),
    .address        (address),
    .read           (read),
    .write          (write),
    .writedata      (writedata),
    .readdata       (readdata),
    .irq            (irq)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    tick(1);
    write     = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    read    = 1'b1;
    tick(1);
    read    = 1'b0;
    d       = readdata;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Holds button2 for 60 cycles while reading FLAGS every cycle; each new set
  // is recorded as the edge it happened on and cleared with a W1C write.
  task automatic run_hold();
    logic prev;
    logic clr_next;
    prev     = 1'b0;
    clr_next = 1'b0;
    nset     = 0;
    address  = A_FLAGS;
    read     = 1'b1;
    buttons_export[2] = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      if (c == 61) buttons_export[2] = 1'b1;
      write     = clr_next;
      writedata = 32'h4;
      tick(1);
      write    = 1'b0;
      clr_next = 1'b0;
      if (readdata[2] && !prev) begin
        if (nset < 8) got[nset] = c - 1;
        nset++;
        clr_next = 1'b1;
      end
      prev = readdata[2];
    end
    read = 1'b0;
  endtask

  int exp_rpt[7] = '{6, 26, 34, 42, 50, 58, 66};

  initial begin
    rst_n          = 1'b1;
    buttons_export = 4'hF;
    switchs_export = 3'h0;
    address        = 2'd0;
    read           = 1'b0;
    write          = 1'b0;
    writedata      = 32'h0;

    // Reset values
    #2 rst_n = 1'b0;
    tick(3);
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    rst_n = 1'b1;
    tick(2);
    rd(A_STATE, rv); check("reset_state", rv, 32'h0);
    rd(A_FLAGS, rv); check("reset_flags", rv, 32'h0);
    rd(A_MASK,  rv); check("reset_mask", rv, 32'h0);
    rd(A_CTRL,  rv); check("reset_ctrl", rv, 32'h0);

    // Button0 pressed with 2-cycle release glitches every 3 cycles
    for (int i = 0; i < 30; i++) begin
      buttons_export[0] = (i % 3 == 0) ? 1'b0 : 1'b1;
      tick(1);
    end
    buttons_export[0] = 1'b1;
    tick(8);
    rd(A_STATE, rv); check("glitch_state", rv, 32'h0);
    rd(A_FLAGS, rv); check("glitch_flags", rv, 32'h0);

    // Button1 steady press: flag on E6, irq on E7
    wr(A_MASK, 32'h2);
    buttons_export[1] = 1'b0;
    tick(5);
    check("press_irq_e5", {31'h0, irq}, 32'h0);
    address = A_FLAGS;
    read    = 1'b1;
    tick(1);
    check("press_flags_before_e6", readdata, 32'h0);
    check("press_irq_e6", {31'h0, irq}, 32'h0);
    tick(1);
    read = 1'b0;
    check("press_flags_after_e6", readdata, 32'h2);
    check("press_irq_e7", {31'h0, irq}, 32'h1);
    rd(A_STATE, rv); check("press_state", rv, 32'h2);
    wr(A_FLAGS, 32'h2);
    tick(1);
    check("w1c_irq_drop", {31'h0, irq}, 32'h0);
    rd(A_FLAGS, rv); check("w1c_flags", rv, 32'h0);
    buttons_export[1] = 1'b1;
    tick(8);
    rd(A_FLAGS, rv); check("release_no_flag", rv, 32'h0);
    rd(A_STATE, rv); check("release_state", rv, 32'h0);

    // Auto-repeat enabled: press, +20, then every 8 while debounced level is high
    wr(A_MASK, 32'h0);
    wr(A_CTRL, 32'h1);
    run_hold();
    check("rpt_on_count", nset, 32'd7);
    for (int k = 0; k < 7; k++) check($sformatf("rpt_on_edge%0d", k), got[k], exp_rpt[k]);

    // Auto-repeat disabled: only the press event
    wr(A_CTRL, 32'h0);
    run_hold();
    check("rpt_off_count", nset, 32'd1);
    check("rpt_off_edge0", got[0], 32'd6);

    // Switch0 both directions set bit4
    switchs_export[0] = 1'b1;
    tick(5);
    rd(A_FLAGS, rv); check("sw_up_before_e6", rv, 32'h0);
    rd(A_FLAGS, rv); check("sw_up_flag", rv, 32'h10);
    rd(A_STATE, rv); check("sw_up_state", rv, 32'h10);
    wr(A_FLAGS, 32'h10);
    rd(A_FLAGS, rv); check("sw_up_cleared", rv, 32'h0);
    switchs_export[0] = 1'b0;
    tick(5);
    rd(A_FLAGS, rv); check("sw_dn_before_e6", rv, 32'h0);
    rd(A_FLAGS, rv); check("sw_dn_flag", rv, 32'h10);
    rd(A_STATE, rv); check("sw_dn_state", rv, 32'h0);
    wr(A_FLAGS, 32'h10);

    // W1C colliding with a new set on E6: set wins
    buttons_export[1] = 1'b0;
    tick(5);
    wr(A_FLAGS, 32'h2);
    rd(A_FLAGS, rv); check("set_wins", rv, 32'h2);
    wr(A_FLAGS, 32'h0);
    rd(A_FLAGS, rv); check("w1c_zero_noop", rv, 32'h2);
    wr(A_FLAGS, 32'h2);
    rd(A_FLAGS, rv); check("w1c_clear", rv, 32'h0);
    wr(A_STATE, 32'hFF);
    rd(A_STATE, rv); check("state_ro", rv, 32'h2);
    wr(A_MASK, 32'hFFFF_FFFF);
    rd(A_MASK, rv); check("mask_width", rv, 32'h7F);
    wr(A_CTRL, 32'hFFFF_FFFF);
    rd(A_CTRL, rv); check("ctrl_width", rv, 32'h1);
    tick(3);
    check("readdata_hold", readdata, 32'h1);
    buttons_export[1] = 1'b1;
    tick(10);
    rd(A_MASK, rv); check("mask_before_reset", rv, 32'h7F);

    // Reset mid-debounce of button3, button3 still held afterwards
    buttons_export[3] = 1'b0;
    tick(3);
    rst_n = 1'b0;
    #1;
    check("midreset_readdata", readdata, 32'h0);
    check("midreset_irq", {31'h0, irq}, 32'h0);
    tick(2);
    rst_n = 1'b1;
    rd(A_STATE, rv); check("postreset_state", rv, 32'h0);
    rd(A_FLAGS, rv); check("postreset_flags", rv, 32'h0);
    rd(A_MASK,  rv); check("postreset_mask", rv, 32'h0);
    rd(A_CTRL,  rv); check("postreset_ctrl", rv, 32'h0);
    tick(1);
    rd(A_FLAGS, rv); check("postreset_before_e6", rv, 32'h0);
    rd(A_FLAGS, rv); check("postreset_press_e6", rv, 32'h8);
    rd(A_STATE, rv); check("postreset_state_b3", rv, 32'h8);
    tick(30);
    rd(A_FLAGS, rv); check("postreset_single", rv, 32'h8);
    wr(A_FLAGS, 32'h8);
    tick(20);
    rd(A_FLAGS, rv); check("postreset_no_more", rv, 32'h0);
    buttons_export[3] = 1'b1;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
